seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the three-digit seven-segment display. It accepts a 12-bit hex value and decimal-point position through a valid/ready handshake and buffers one pending update. It commits updates only at frame boundaries, so a displayed frame never shows a mix of old and new digits. It then steps a 2-bit digit index and drives matching active-low segment data. It sits directly upstream of the 2-to-4 anode decoder: `digit_sel` drives the decoder's 2-bit select. Index 3 is the all-anodes-off code.

---
 rtl/seg_pkg.sv | 14 +
 rtl/seg_scan_ctrl_hex_to_seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 113 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] DIG_OFF   = 2'd3;
  localparam logic [1:0] DP_NONE   = 2'd3;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment encoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[digit];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Three-digit seven-segment scan controller with frame-aligned update commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_en,
  input  logic        load_valid,
  input  logic [11:0] load_value,
  input  logic [1:0]  load_dp,
  output logic        load_ready,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             boundary;
  logic             commit;
  logic             pend_valid;
  logic [11:0]      pend_val;
  logic [1:0]       pend_dp;
  logic [11:0]      disp_val;
  logic [1:0]       disp_dp;
  logic [1:0]       sel_nxt;
  logic [11:0]      val_nxt;
  logic [1:0]       dp_nxt;
  logic [3:0]       nib;
  logic [6:0]       hex_seg;
  logic [6:0]       seg_nxt;
  logic             dp_n_nxt;
  logic             blank;

  assign load_ready = !pend_valid;
  assign tick       = disp_en && (cnt == CNT_W'(TICK_DIV - 1));

  // Outputs are computed from the post-edge selection and value so that a
  // committed update is visible on the very edge that commits it.
  always_comb begin
    sel_nxt = digit_sel;
    if (!disp_en) begin
      sel_nxt = DIG_OFF;
    end else if (tick) begin
      case (digit_sel)
        2'd0:    sel_nxt = 2'd1;
        2'd1:    sel_nxt = 2'd2;
        default: sel_nxt = 2'd0;
      endcase
    end
    boundary = tick && (sel_nxt == 2'd0);
    commit   = boundary && pend_valid;
    val_nxt  = commit ? pend_val : disp_val;
    dp_nxt   = commit ? pend_dp  : disp_dp;
  end

  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    case (sel_nxt)
      2'd0:    nib = val_nxt[3:0];
      2'd1:    nib = val_nxt[7:4];
      2'd2:    nib = val_nxt[11:8];
      default: blank = 1'b1;
    endcase
`ifdef SEG_SCAN_LZB_EN
    if ((sel_nxt == 2'd2) && (val_nxt[11:8] == 4'd0)) blank = 1'b1;
    if ((sel_nxt == 2'd1) && (val_nxt[11:4] == 8'd0)) blank = 1'b1;
`endif
    seg_nxt  = blank ? SEG_BLANK : hex_seg;
    dp_n_nxt = !((sel_nxt == dp_nxt) && (dp_nxt != DP_NONE));
  end

  hex_to_seg u_hex_to_seg (
    .digit (nib),
    .seg   (hex_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      digit_sel  <= DIG_OFF;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      disp_val   <= 12'd0;
      disp_dp    <= DP_NONE;
      pend_valid <= 1'b0;
    end else begin
      if (!disp_en || tick) cnt <= '0;
      else                  cnt <= cnt + CNT_W'(1);
      digit_sel <= sel_nxt;
      seg_n     <= seg_nxt;
      dp_n      <= dp_n_nxt;
      disp_val  <= val_nxt;
      disp_dp   <= dp_nxt;
      if (commit)                        pend_valid <= 1'b0;
      else if (load_valid && !pend_valid) pend_valid <= 1'b1;
    end
  end

  // Pending data only matters once pend_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_valid && !pend_valid) begin
      pend_val <= load_value;
      pend_dp  <= load_dp;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a slot-counting reference model.
module tb_seg_scan_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_en;
  logic        load_valid;
  logic [11:0] load_value;
  logic [1:0]  load_dp;
  logic        load_ready;
  logic [1:0]  digit_sel;
  logic [6:0]  seg_n;
  logic        dp_n;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_en    (disp_en),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_dp    (load_dp),
    .load_ready (load_ready),
    .digit_sel  (digit_sel),
    .seg_n      (seg_n),
    .dp_n       (dp_n)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: cycles since enable -> slot number -> digit.
  int          en_cnt = 0;
  logic [11:0] m_val  = 12'd0;
  logic [1:0]  m_dp   = 2'd3;
  bit          m_pend = 1'b0;
  logic [11:0] p_val  = 12'd0;
  logic [1:0]  p_dp   = 2'd3;
  bit          accepted = 1'b0;

  function automatic exp_t expect_out();
    exp_t e;
    int slot, d;
    logic [3:0] nibv;
    e.rdy = !m_pend;
    e.sel = 2'd3;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    slot  = en_cnt / TD;
    if (slot > 0) begin
      d     = (slot - 1) % 3;
      e.sel = d[1:0];
      nibv  = 4'((m_val >> (4 * d)) & 12'hF);
      e.seg = hex_tab[nibv];
`ifdef SEG_SCAN_LZB_EN
      if ((d == 2 && m_val[11:8] == 4'd0) || (d == 1 && m_val[11:4] == 8'd0))
        e.seg = 7'h7F;
`endif
      e.dp = (int'(m_dp) == d) ? 1'b0 : 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    bit acc;
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      en_cnt = 0;
      m_val  = 12'd0;
      m_dp   = 2'd3;
      m_pend = 1'b0;
    end else begin
      acc = load_valid && !m_pend;
      if (disp_en) begin
        en_cnt++;
        if ((en_cnt % TD == 0) && (((en_cnt / TD) - 1) % 3 == 0) && m_pend) begin
          m_val  = p_val;
          m_dp   = p_dp;
          m_pend = 1'b0;
        end
      end else begin
        en_cnt = 0;
      end
      if (acc) begin
        p_val    = load_value;
        p_dp     = load_dp;
        m_pend   = 1'b1;
        accepted = 1'b1;
      end
    end
    q.push_back(expect_out());
    #2;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input logic [11:0] v, input logic [1:0] d);
    bit done;
    done       = 1'b0;
    load_valid = 1'b1;
    load_value = v;
    load_dp    = d;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = accepted;
    end
    load_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL handshake: value %h not accepted within 40 cycles, want accepted", v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      total++;
      if ({digit_sel, seg_n, dp_n, load_ready} !== mon_e) begin
        bad++;
        $display("FAIL outputs @%0t: got sel=%0d seg=%h dp_n=%b rdy=%b, want sel=%0d seg=%h dp_n=%b rdy=%b",
                 $time, digit_sel, seg_n, dp_n, load_ready,
                 mon_e.sel, mon_e.seg, mon_e.dp, mon_e.rdy);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    disp_en    = 1'b0;
    load_valid = 1'b0;
    load_value = 12'd0;
    load_dp    = 2'd0;
    cycles(2);
    rst     = 1'b0;
    disp_en = 1'b1;
    cycles(30);

    cycles(5);
    offer(12'h3A7, 2'd1);
    cycles(30);

    offer(12'h111, 2'd3);
    offer(12'h222, 2'd0);
    cycles(30);

    cycles(5);
    disp_en = 1'b0;
    cycles(6);
    disp_en = 1'b1;
    cycles(10);

    disp_en = 1'b0;
    offer(12'h5A5, 2'd0);
    cycles(3);
    disp_en = 1'b1;
    cycles(20);

    offer(12'h999, 2'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cycles(20);

    offer(12'h005, 2'd0);
    cycles(15);

    for (int i = 0; i < 400; i++) begin
      disp_en = ($urandom_range(0, 19) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      if (!load_valid || accepted) begin
        load_valid = ($urandom_range(0, 2) == 0);
        load_value = 12'($urandom);
        load_dp    = 2'($urandom);
      end
      step();
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    disp_en    = 1'b1;
    cycles(15);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
